// File: rtl/ballot_ctrl_pkg.sv
// Shared definitions for the ballot-unit controller: FSM encoding,
// candidate count, tally width and a small press-counting helper.
package ballot_ctrl_pkg;

   localparam int NUM_CAND = 3;
   localparam int TOTAL_W  = 6;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ARMED   = 3'd1,
      S_COMMIT  = 3'd2,
      S_RELEASE = 3'd3,
      S_REJECT  = 3'd4,
      S_CLOSED  = 3'd5
   } state_t;

   // Number of debounced buttons currently high (0..3).
   function automatic logic [1:0] count_high(input logic [NUM_CAND-1:0] v);
      logic [1:0] n;
      n = '0;
      for (int i = 0; i < NUM_CAND; i++) n = n + 2'(v[i]);
      return n;
   endfunction

endpackage

// File: rtl/ballot_ctrl_btn_debounce.sv
// One candidate button: 2-flop synchronizer followed by a saturating
// high-sample counter. The debounced level rises on the DEBOUNCE_CYCLES-th
// consecutive high sample and drops on the first low sample.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn,
   output logic o_db
);

   logic       r_s1;
   logic       r_s2;
   logic [3:0] r_cnt;
   logic       r_db;

   // Synchronize the raw button, then count consecutive high samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_cnt <= '0;
         r_db  <= 1'b0;
      end else begin
         r_s1 <= i_btn;
         r_s2 <= r_s1;
         if (!r_s2) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
         end else if (r_cnt != 4'(DEBOUNCE_CYCLES)) begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == 4'(DEBOUNCE_CYCLES - 1)) r_db <= 1'b1;
         end
      end
   end

   assign o_db = r_db;

endmodule

// File: rtl/ballot_ctrl.sv
// Ballot-unit controller: arms one vote per issued ballot, rejects
// simultaneous presses, expires unused ballots and closes the poll.
// All outputs are registered. o_dbg_state exposes the FSM state.
module ballot_ctrl
   import ballot_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int TIMEOUT_CYCLES  = 64,
   parameter int MAX_BALLOTS     = 63
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_ballot_issue,
   input  logic               candidate_1,
   input  logic               candidate_2,
   input  logic               candidate_3,
   input  logic               i_close_poll,
   output logic [2:0]         o_vote,
   output logic               o_voting_over,
   output logic               o_ready,
   output logic               o_err_multi,
   output logic               o_timeout,
   output logic               o_full,
   output logic [TOTAL_W-1:0] o_ballots,
   output state_t             o_dbg_state
);

   logic [NUM_CAND-1:0] w_db;
   logic [1:0]          w_n_high;
   logic                w_issue_edge;
   logic                w_close;

   state_t              r_state;
   logic                r_issue_d;
   logic                r_close_pend;
   logic [7:0]          r_tmo;
   logic [2:0]          r_vote;
   logic                r_over;
   logic                r_ready;
   logic                r_err;
   logic                r_timeout;
   logic                r_full;
   logic [TOTAL_W-1:0]  r_ballots;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
      .clk(clk), .rst(rst), .i_btn(candidate_1), .o_db(w_db[0]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
      .clk(clk), .rst(rst), .i_btn(candidate_2), .o_db(w_db[1]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db3 (
      .clk(clk), .rst(rst), .i_btn(candidate_3), .o_db(w_db[2]));

   assign w_n_high     = count_high(w_db);
   assign w_issue_edge = i_ballot_issue & ~r_issue_d;
   // A close seen while a vote is in flight is honoured once back in IDLE/ARMED.
   assign w_close      = i_close_poll | r_close_pend;

   // Remember the previous ballot-issue level for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) r_issue_d <= 1'b0;
      else     r_issue_d <= i_ballot_issue;
   end

   // Ballot FSM with timeout counter, ballot counter and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_close_pend <= 1'b0;
         r_tmo        <= '0;
         r_vote       <= '0;
         r_over       <= 1'b0;
         r_ready      <= 1'b0;
         r_err        <= 1'b0;
         r_timeout    <= 1'b0;
         r_full       <= 1'b0;
         r_ballots    <= '0;
      end else begin
         r_vote    <= '0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
         if (i_close_poll && (r_state == S_COMMIT || r_state == S_RELEASE ||
                              r_state == S_REJECT))
            r_close_pend <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_close) begin
                  r_state      <= S_CLOSED;
                  r_over       <= 1'b1;
                  r_close_pend <= 1'b0;
               end else if (w_issue_edge && !r_full) begin
                  r_state <= S_ARMED;
                  r_tmo   <= '0;
                  r_ready <= 1'b1;
               end
            end
            S_ARMED: begin
               if (w_close) begin
                  r_state      <= S_CLOSED;
                  r_over       <= 1'b1;
                  r_ready      <= 1'b0;
                  r_close_pend <= 1'b0;
               end else if (w_n_high >= 2'd2) begin
                  r_state <= S_REJECT;
                  r_err   <= 1'b1;
                  r_ready <= 1'b0;
               end else if (w_n_high == 2'd1) begin
                  r_state <= S_COMMIT;
                  r_vote  <= w_db;
                  r_ready <= 1'b0;
                  if (r_ballots != TOTAL_W'(MAX_BALLOTS)) begin
                     r_ballots <= r_ballots + 1'b1;
                     r_full    <= (r_ballots + 1'b1 == TOTAL_W'(MAX_BALLOTS));
                  end
               end else if (r_tmo == 8'(TIMEOUT_CYCLES - 1)) begin
                  r_state   <= S_IDLE;
                  r_timeout <= 1'b1;
                  r_ready   <= 1'b0;
               end else begin
                  r_tmo <= r_tmo + 8'd1;
               end
            end
            S_COMMIT: r_state <= S_RELEASE;
            S_RELEASE: begin
               if (w_db == '0) r_state <= S_IDLE;
            end
            S_REJECT: begin
               if (w_db == '0) begin
                  r_state <= S_ARMED;
                  r_tmo   <= '0;
                  r_ready <= 1'b1;
               end
            end
            S_CLOSED: r_state <= S_CLOSED;
            default:  r_state <= S_IDLE;
         endcase
      end
   end

   assign o_vote        = r_vote;
   assign o_voting_over = r_over;
   assign o_ready       = r_ready;
   assign o_err_multi   = r_err;
   assign o_timeout     = r_timeout;
   assign o_full        = r_full;
   assign o_ballots     = r_ballots;
   assign o_dbg_state   = r_state;

endmodule
